branch_cond_unit: RTL and testbench
===================================

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 SHALL have parameter W, default 16, operand/PC width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have ports cmp_lt, cmp_gt, cmp_eq  input  1 each  unsigned compare result from the 16-bit comparator.
REQ-007 SHALL have ports sign_a, sign_b  input  1 each  MSBs of the compared operands.
REQ-008 SHALL have port is_signed  input  1  1 = signed comparison.
REQ-009 SHALL have port cond  input  3  branch condition.
REQ-010 SHALL have ports pc, offset  input  W each  current PC, branch offset.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have ports taken  output  1, next_pc  output  W, err  output  1  branch result.
REQ-014 SHALL have port flags  output  3  status {LT,EQ,GT} of the last good evaluation.

Function
REQ-015 SHALL implement FSM IDLE -> EVAL -> RESP -> IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready on a rising edge.
REQ-017 On accept, SHALL capture all request inputs into a stage register and enter EVAL.
REQ-018 EVAL SHALL last exactly one cycle, register taken/next_pc/err, and enter RESP; out_valid rises 2 edges after the accept edge.
REQ-019 In RESP, out_valid=1 with outputs stable until out_ready=1; that edge returns to IDLE; out_ready outside RESP is ignored.
REQ-020 Effective compare: if is_signed & (sign_a != sign_b): lt=sign_a, gt=sign_b, eq=0; otherwise lt/gt/eq = cmp_lt/cmp_gt/cmp_eq.
REQ-021 cond encoding: 000 EQ, 001 NE, 010 LT, 011 GE (gt|eq), 100 GT, 101 LE (lt|eq), 110 ALWAYS, 111 NEVER.
REQ-022 next_pc SHALL be pc+offset when taken, else pc+1; both modulo 2^W, no carry out.
REQ-023 err SHALL be 1 when the captured cmp_lt/cmp_gt/cmp_eq is not exactly one-hot; the signed override of REQ-020 does not suppress err; then taken=0, next_pc=pc+1, flags not updated.
REQ-024 flags SHALL load {lt,eq,gt} at the end of EVAL when err=0, and hold otherwise.
REQ-025 Inputs changing while not in IDLE SHALL have no effect on the in-flight result.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, out_valid=0, taken=0, next_pc=0, err=0, flags=000, without waiting for clk.
REQ-027 Reset during EVAL or RESP SHALL discard the transaction; no out_valid for it after release.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-029 Unsigned BLT: cmp_lt=1, is_signed=0, cond=010, pc=0x0010, offset=0x0005 -> out_valid 2 edges after accept, taken=1, next_pc=0x0015, flags=100.
REQ-030 Signed override: cmp_gt=1, sign_a=1, sign_b=0, is_signed=1, cond=100, pc=0x0100 -> taken=0, next_pc=0x0101, flags=100.
REQ-031 Wrap-around: cond=110, pc=0xFFFF, offset=0x0003 -> taken=1, next_pc=0x0002; cond=111, pc=0xFFFF -> taken=0, next_pc=0x0000.
REQ-032 Backpressure: out_ready=0 for 5 cycles in RESP, upstream inputs changed meanwhile -> out_valid/taken/next_pc unchanged, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-033 Illegal compare: cmp_lt=1, cmp_eq=1, cond=000 -> err=1, taken=0, next_pc=pc+1, flags keep previous value.
REQ-034 Reset mid-op: rst_n low for one cycle during EVAL -> out_valid stays 0, flags=000, in_ready=1 in the cycle after release.

Source files
------------

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: evaluates a branch condition from comparator flags and returns taken/next_pc over a valid/ready handshake.
module branch_cond_unit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cmp_lt,
  input  logic         cmp_gt,
  input  logic         cmp_eq,
  input  logic         sign_a,
  input  logic         sign_b,
  input  logic         is_signed,
  input  logic [2:0]   cond,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] offset,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic [W-1:0] next_pc,
  output logic         err,
  output logic [2:0]   flags
);
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t state, state_d;
  logic s_lt, s_gt, s_eq, s_sa, s_sb, s_sig;
  logic [2:0] s_cond;
  logic [W-1:0] s_pc, s_off, npc;
  logic ovr, lt, gt, eq, bad, tk;
  logic [7:0] hit_tab;
  assign in_ready  = state == IDLE;
  assign out_valid = state == RESP;
  always_comb begin
    state_d = (state == IDLE) ? (in_valid ? EVAL : IDLE) :
              (state == EVAL) ? RESP : (out_ready ? IDLE : RESP);
  end
  // Differing operand signs decide a signed compare regardless of the unsigned comparator.
  always_comb begin
    ovr     = s_sig & (s_sa ^ s_sb);
    lt      = ovr ? s_sa : s_lt;
    gt      = ovr ? s_sb : s_gt;
    eq      = ovr ? 1'b0 : s_eq;
    bad     = ~(s_lt ^ s_gt ^ s_eq) | (s_lt & s_gt & s_eq);
    hit_tab = {1'b0, 1'b1, lt | eq, gt, gt | eq, lt, ~eq, eq};
    tk      = hit_tab[s_cond] & ~bad;
    npc     = tk ? s_pc + s_off : s_pc + {{(W-1){1'b0}}, 1'b1};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s_lt, s_gt, s_eq, s_sa, s_sb, s_sig} <= '0;
      s_cond  <= '0;
      s_pc    <= '0;
      s_off   <= '0;
      taken   <= 1'b0;
      next_pc <= '0;
      err     <= 1'b0;
      flags   <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        {s_lt, s_gt, s_eq, s_sa, s_sb, s_sig} <= {cmp_lt, cmp_gt, cmp_eq, sign_a, sign_b, is_signed};
        s_cond <= cond;
        s_pc   <= pc;
        s_off  <= offset;
      end
      if (state == EVAL) begin
        taken   <= tk;
        next_pc <= npc;
        err     <= bad;
        if (!bad) flags <= {lt, eq, gt};
      end
    end
  end
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed and randomized checks of branch_cond_unit against a behavioural model.
module tb_branch_cond_unit;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic cmp_lt = 0, cmp_gt = 0, cmp_eq = 0, sign_a = 0, sign_b = 0, is_signed = 0;
  logic [2:0] cond = 0;
  logic [15:0] pc = 0, offset = 0;
  logic in_ready, out_valid, taken, err;
  logic [15:0] next_pc;
  logic [2:0] flags;
  int checks = 0, errors = 0;
  logic [2:0] exp_flags = 0;

  branch_cond_unit #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .sign_a(sign_a), .sign_b(sign_b),
    .is_signed(is_signed), .cond(cond), .pc(pc), .offset(offset),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .next_pc(next_pc),
    .err(err), .flags(flags)
  );

  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Effective {lt,eq,gt} from raw comparator bits {lt,gt,eq} and operand signs.
  function automatic logic [2:0] eff(input logic [2:0] c, input logic sa, sb, sg);
    if (sg && sa != sb) return {sa, 1'b0, sb};
    return {c[2], c[0], c[1]};
  endfunction

  function automatic logic hit(input logic [2:0] cd, input logic [2:0] f);
    logic l, e, g;
    {l, e, g} = f;
    case (cd)
      3'd0: return e;
      3'd1: return !e;
      3'd2: return l;
      3'd3: return g || e;
      3'd4: return g;
      3'd5: return l || e;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic scramble();
    {cmp_lt, cmp_gt, cmp_eq, sign_a, sign_b, is_signed} = 6'($urandom);
    cond = 3'($urandom);
    pc = 16'($urandom);
    offset = 16'($urandom);
  endtask

  // c = {lt,gt,eq}; f = expected effective {lt,eq,gt}; e = expected err.
  task automatic run(input logic [2:0] c, input logic sa, sb, sg, input logic [2:0] cd,
                     input logic [15:0] p, o, input logic [2:0] f, input logic e, input int hold);
    logic tk;
    logic [15:0] np;
    tk = !e && hit(cd, f);
    np = tk ? p + o : p + 16'd1;
    if (!e) exp_flags = f;
    @(negedge clk);
    {cmp_lt, cmp_gt, cmp_eq} = c;
    {sign_a, sign_b, is_signed} = {sa, sb, sg};
    cond = cd; pc = p; offset = o;
    in_valid = 1; out_ready = 0;
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    scramble();
    @(negedge clk);
    chk("eval_out_valid", out_valid, 0);
    @(negedge clk);
    chk("resp_out_valid", out_valid, 1);
    chk("taken", taken, tk);
    chk("next_pc", next_pc, np);
    chk("err", err, e);
    chk("flags", flags, exp_flags);
    chk("resp_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      scramble();
      in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_taken", taken, tk);
      chk("hold_next_pc", next_pc, np);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("done_in_ready", in_ready, 1);
    chk("done_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [15:0] a, b;
    logic [2:0] c, f;
    logic sg, e;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_taken", taken, 0);
    chk("rst_next_pc", next_pc, 0);
    chk("rst_err", err, 0);
    chk("rst_flags", flags, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    // unsigned BLT
    run(3'b100, 0, 0, 0, 3'd2, 16'h0010, 16'h0005, 3'b100, 0, 0);
    // signed override: unsigned says GT but a is negative
    run(3'b010, 1, 0, 1, 3'd4, 16'h0100, 16'h0040, eff(3'b010, 1, 0, 1), 0, 0);
    run(3'b001, 0, 0, 0, 3'd6, 16'hFFFF, 16'h0003, 3'b010, 0, 0);
    run(3'b001, 0, 0, 0, 3'd7, 16'hFFFF, 16'h0003, 3'b010, 0, 0);
    // backpressure with upstream churn
    run(3'b010, 0, 0, 0, 3'd3, 16'h1234, 16'h0100, 3'b001, 0, 5);
    // illegal compare: flags must keep 001
    run(3'b101, 0, 0, 0, 3'd0, 16'h0200, 16'h0010, 3'b000, 1, 0);
    run(3'b000, 0, 0, 0, 3'd6, 16'h0300, 16'h0010, 3'b000, 1, 1);
    // reset during EVAL
    @(negedge clk);
    {cmp_lt, cmp_gt, cmp_eq} = 3'b100; cond = 3'd6; pc = 16'h0500; offset = 16'h0001;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_next_pc", next_pc, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_flags = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("after_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_out_valid", out_valid, 0);
    end
    // random operands; expectations from true signed/unsigned compare
    for (int n = 0; n < 60; n++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
      sg = 1'($urandom);
      e = ($urandom_range(0, 7) == 0);
      if (sg) f = {$signed(a) < $signed(b), a == b, $signed(a) > $signed(b)};
      else    f = {a < b, a == b, a > b};
      c = {a < b, a > b, a == b};
      if (e) c = ($urandom_range(0, 1) == 0) ? 3'b000 : (3'b011 << $urandom_range(0, 1)) | 3'($urandom_range(0, 1) << 2);
      if ($countones(c) == 1) e = 0;
      run(c, a[15], b[15], sg, 3'($urandom), 16'($urandom), 16'($urandom), f, e, $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
